// File: rtl/spi_master_if.sv
// Bus and handshake signals of the 16-bit SPI master.
// The master drives the serial lines; the slave side is the requester plus the SPI slave.
interface spi_master_if;
    logic        START;
    logic [15:0] TX_DATA;
    logic [15:0] RX_DATA;
    logic        BUSY;
    logic        DONE;
    logic        SCLK;
    logic        CS;
    logic        MOSI;
    logic        MISO;

    modport master (
        input  START, TX_DATA, MISO,
        output RX_DATA, BUSY, DONE, SCLK, CS, MOSI
    );

    modport slave (
        output START, TX_DATA, MISO,
        input  RX_DATA, BUSY, DONE, SCLK, CS, MOSI
    );
endinterface

// File: rtl/spi_master.sv
// 16-bit LSB-first SPI master. SCLK idles low, and both sides shift on the SCLK rise.
// The first SCLK rise of a frame only synchronizes. CS stays low for 35*CLK_DIV cycles.
module spi_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic         CLK,
    input  logic         RST_N,
    spi_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    // The IDLE cycle that accepts a held START is also a CS-high cycle.
    // GAP therefore lasts one cycle less than CS_GAP.
    localparam logic [7:0] GAP_LAST = 8'((CS_GAP > 1) ? CS_GAP - 2 : 0);
    localparam logic [4:0] EDGE_MAX = 5'd16;

    state_t      state, state_d;
    logic [7:0]  hcnt, hcnt_d;
    logic [4:0]  edge_cnt, edge_cnt_d;
    logic [15:0] tx_sr, tx_sr_d, rx_sr, rx_sr_d, rx_data, rx_data_d;
    logic        sclk, sclk_d, cs, cs_d, mosi, mosi_d, busy, busy_d, done, done_d;
    logic        phase_end;

    assign phase_end = (hcnt == DIV_LAST);

    always_comb begin
        state_d    = state;
        hcnt_d     = hcnt + 8'd1;
        edge_cnt_d = edge_cnt;
        tx_sr_d    = tx_sr;
        rx_sr_d    = rx_sr;
        rx_data_d  = rx_data;
        sclk_d     = sclk;
        cs_d       = cs;
        mosi_d     = mosi;
        done_d     = 1'b0;
        case (state)
            IDLE: begin
                hcnt_d = 8'd0;
                if (bus.START) begin
                    state_d    = LEAD;
                    tx_sr_d    = bus.TX_DATA;
                    rx_sr_d    = 16'd0;
                    cs_d       = 1'b0;
                    mosi_d     = bus.TX_DATA[0];
                    edge_cnt_d = 5'd0;
                end
            end
            LEAD: begin
                if (phase_end) begin
                    hcnt_d  = 8'd0;
                    sclk_d  = 1'b1;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (phase_end) begin
                    hcnt_d = 8'd0;
                    if (sclk) begin
                        sclk_d = 1'b0;
                        if (edge_cnt == EDGE_MAX) begin
                            state_d = TRAIL;
                        end else if (edge_cnt != 5'd0) begin
                            // Falling edge after rise k presents tx bit k.
                            mosi_d  = tx_sr[1];
                            tx_sr_d = {tx_sr[0], tx_sr[15:1]};
                        end
                    end else begin
                        sclk_d     = 1'b1;
                        edge_cnt_d = (edge_cnt == EDGE_MAX) ? EDGE_MAX : edge_cnt + 5'd1;
                        rx_sr_d    = {bus.MISO, rx_sr[15:1]};
                    end
                end
            end
            TRAIL: begin
                if (phase_end) begin
                    hcnt_d    = 8'd0;
                    cs_d      = 1'b1;
                    done_d    = 1'b1;
                    rx_data_d = rx_sr;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (hcnt == GAP_LAST) begin
                    hcnt_d  = 8'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            hcnt     <= 8'd0;
            edge_cnt <= 5'd0;
            tx_sr    <= 16'd0;
            rx_sr    <= 16'd0;
            rx_data  <= 16'd0;
            sclk     <= 1'b0;
            cs       <= 1'b1;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            hcnt     <= hcnt_d;
            edge_cnt <= edge_cnt_d;
            tx_sr    <= tx_sr_d;
            rx_sr    <= rx_sr_d;
            rx_data  <= rx_data_d;
            sclk     <= sclk_d;
            cs       <= cs_d;
            mosi     <= mosi_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    assign bus.SCLK    = sclk;
    assign bus.CS      = cs;
    assign bus.MOSI    = mosi;
    assign bus.BUSY    = busy;
    assign bus.DONE    = done;
    assign bus.RX_DATA = rx_data;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: slave-model scoreboard on a CLK_DIV=4 instance and a CLK_DIV=1 loopback instance.
module tb_spi_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic [15:0] rx;
        logic [15:0] tx;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    logic [15:0] slv_in = 16'd0;
    logic [15:0] slv_out = 16'd0;
    logic [15:0] slv_din = 16'd0;
    logic        slv_first = 1'b0;

    spi_master_if b4();
    spi_master_if b1();

    spi_master #(.CLK_DIV(4), .CS_GAP(2)) dut    (.CLK(clk), .RST_N(rst_n), .bus(b4));
    spi_master #(.CLK_DIV(1), .CS_GAP(2)) dut_lb (.CLK(clk), .RST_N(rst_n), .bus(b1));

    always #5 clk = ~clk;

    assign b1.MISO = b1.MOSI;
    assign b4.MISO = slv_out[0];

    // Slave: the first SCLK rise after CS falls only synchronizes; later rises sample MOSI and shift MISO.
    always @(negedge b4.CS) begin
        slv_out   <= slv_in;
        slv_din   <= 16'd0;
        slv_first <= 1'b1;
    end
    always @(posedge b4.SCLK) begin
        if (!b4.CS) begin
            if (slv_first) slv_first <= 1'b0;
            else begin
                slv_din <= {b4.MOSI, slv_din[15:1]};
                slv_out <= {1'b0, slv_out[15:1]};
            end
        end
    end

    // Frame monitor for the CLK_DIV=4 instance.
    int   cs_low_cyc = 0;
    int   sclk_rises = 0;
    int   done_cnt = 0;
    logic sclk_q = 1'b0;
    logic done_q = 1'b0;
    always @(negedge clk) begin
        if (!b4.CS) begin
            cs_low_cyc++;
            if (b4.SCLK && !sclk_q) sclk_rises++;
        end
        if (b4.DONE) begin
            done_cnt++;
            total++;
            if (done_q) begin bad++; $display("FAIL done_width DONE high two cycles in a row"); end
            total++;
            if (sb.size() == 0) begin
                bad++; $display("FAIL unexpected_done got DONE with no frame expected");
            end else begin
                e = sb.pop_front();
                total++;
                if (b4.RX_DATA !== e.rx) begin bad++; $display("FAIL rx_data got=%h want=%h", b4.RX_DATA, e.rx); end
                total++;
                if (slv_din !== e.tx) begin bad++; $display("FAIL slave_data_out got=%h want=%h", slv_din, e.tx); end
                total++;
                if (cs_low_cyc != 140) begin bad++; $display("FAIL cs_low_len got=%0d want=140", cs_low_cyc); end
                total++;
                if (sclk_rises != 17) begin bad++; $display("FAIL sclk_rises got=%0d want=17", sclk_rises); end
            end
        end
        if (b4.CS) begin cs_low_cyc = 0; sclk_rises = 0; end
        sclk_q = b4.SCLK;
        done_q = b4.DONE;
    end

    task automatic start_frame(input logic [15:0] tx, input logic [15:0] sin);
        @(negedge clk);
        slv_in     = sin;
        b4.TX_DATA = tx;
        b4.START   = 1'b1;
        sb.push_back('{rx: sin, tx: tx});
        @(negedge clk);
        b4.START = 1'b0;
        total++;
        if (b4.BUSY !== 1'b1) begin bad++; $display("FAIL busy_after_start got=%b want=1", b4.BUSY); end
    endtask

    task automatic wait_done(input int n);
        int d0 = done_cnt;
        int i = 0;
        while (done_cnt == d0 && i < n) begin @(negedge clk); i++; end
        if (done_cnt == d0) begin
            total++; bad++; $display("FAIL done_timeout no DONE within %0d cycles", n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        b4.START = 1'b0; b4.TX_DATA = 16'd0;
        b1.START = 1'b0; b1.TX_DATA = 16'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({b4.CS, b4.SCLK, b4.MOSI, b4.BUSY, b4.DONE} !== 5'b10000) begin
            bad++; $display("FAIL reset_ctl got=%b want=10000", {b4.CS, b4.SCLK, b4.MOSI, b4.BUSY, b4.DONE});
        end
        total++;
        if (b4.RX_DATA !== 16'd0) begin bad++; $display("FAIL reset_rx got=%h want=0000", b4.RX_DATA); end
        total++;
        if ({b1.CS, b1.SCLK, b1.BUSY} !== 3'b100) begin
            bad++; $display("FAIL reset_lb_ctl got=%b want=100", {b1.CS, b1.SCLK, b1.BUSY});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({b4.CS, b4.BUSY} !== 2'b10) begin bad++; $display("FAIL idle_after_reset got=%b want=10", {b4.CS, b4.BUSY}); end
    endtask

    task automatic test_loopback();
        int cs_n = 0, rises = 0, dn = 0;
        logic p = 1'b0;
        @(negedge clk);
        b1.TX_DATA = 16'hA5C3;
        b1.START   = 1'b1;
        @(negedge clk);
        b1.START = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!b1.CS) begin
                cs_n++;
                if (b1.SCLK && !p) rises++;
            end
            if (b1.DONE) dn++;
            p = b1.SCLK;
            @(negedge clk);
        end
        total++;
        if (dn != 1) begin bad++; $display("FAIL lb_done_count got=%0d want=1", dn); end
        total++;
        if (b1.RX_DATA !== 16'hA5C3) begin bad++; $display("FAIL lb_rx got=%h want=a5c3", b1.RX_DATA); end
        total++;
        if (cs_n != 35) begin bad++; $display("FAIL lb_cs_low got=%0d want=35", cs_n); end
        total++;
        if (rises != 17) begin bad++; $display("FAIL lb_rises got=%0d want=17", rises); end
    endtask

    task automatic test_patterns();
        logic [15:0] tx_t [5] = '{16'hBEEF, 16'h0000, 16'hFFFF, 16'h8001, 16'h1357};
        logic [15:0] rx_t [5] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h7FFE, 16'hECA8};
        for (int i = 0; i < 5; i++) begin
            start_frame(tx_t[i], rx_t[i]);
            wait_done(300);
        end
        start_frame(16'($urandom), 16'($urandom));
        wait_done(300);
    endtask

    task automatic test_start_ignored();
        int d0 = done_cnt, busy_low = 0, cs_low = 0;
        start_frame(16'h6B2D, 16'hD4C1);
        repeat (9) @(negedge clk);
        b4.TX_DATA = 16'hFFFF;
        b4.START   = 1'b1;
        @(negedge clk);
        b4.START = 1'b0;
        for (int i = 0; i < 300 && done_cnt == d0; i++) begin
            if (!b4.BUSY) busy_low++;
            @(negedge clk);
        end
        total++;
        if (busy_low != 0) begin bad++; $display("FAIL busy_dropped got=%0d low cycles want=0", busy_low); end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!b4.CS) cs_low++;
        end
        total++;
        if (cs_low != 0) begin bad++; $display("FAIL start_queued got=%0d cs-low cycles want=0", cs_low); end
        total++;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL ignored_done_count got=%0d want=1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt, hi = 0;
        logic seen = 1'b0, fin = 1'b0;
        @(negedge clk);
        slv_in     = 16'h0F0F;
        b4.TX_DATA = 16'hC001;
        b4.START   = 1'b1;
        sb.push_back('{rx: 16'h0F0F, tx: 16'hC001});
        sb.push_back('{rx: 16'hF0F0, tx: 16'h3CC3});
        @(negedge clk);
        b4.TX_DATA = 16'h3CC3;
        slv_in     = 16'hF0F0;
        for (int i = 0; i < 400 && !fin; i++) begin
            @(posedge clk); #1;
            if (b4.DONE) seen = 1'b1;
            if (seen) begin
                if (b4.CS) hi++;
                else begin fin = 1'b1; b4.START = 1'b0; end
            end
        end
        b4.START = 1'b0;
        total++;
        if (!fin || hi != 2) begin bad++; $display("FAIL cs_gap got=%0d (restarted=%b) want=2", hi, fin); end
        wait_done(300);
        total++;
        if (done_cnt - d0 != 2) begin bad++; $display("FAIL b2b_done_count got=%0d want=2", done_cnt - d0); end
    endtask

    task automatic test_reset_midframe();
        int r = 0, d0;
        logic p = 1'b0;
        start_frame(16'hA00A, 16'h0550);
        for (int i = 0; i < 200 && r < 9; i++) begin
            @(posedge clk); #1;
            if (!b4.CS && b4.SCLK && !p) r++;
            p = b4.SCLK;
        end
        rst_n = 1'b0;
        #1;
        sb.delete();
        d0 = done_cnt;
        total++;
        if (r != 9 || {b4.CS, b4.SCLK, b4.BUSY} !== 3'b100) begin
            bad++; $display("FAIL midframe_reset got=%b rises=%0d want=100 rises=9", {b4.CS, b4.SCLK, b4.BUSY}, r);
        end
        repeat (3) @(negedge clk);
        total++;
        if (b4.RX_DATA !== 16'd0) begin bad++; $display("FAIL midframe_rx got=%h want=0000", b4.RX_DATA); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (done_cnt != d0) begin bad++; $display("FAIL abort_done got=%0d want=%0d", done_cnt, d0); end
        start_frame(16'h5AA5, 16'h9669);
        wait_done(300);
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_patterns();
        test_start_ignored();
        test_back_to_back();
        test_reset_midframe();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL missing_done got=%0d pending want=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, meaning: CLK cycles per SCLK half-period; legal range 1..255.
REQ-002 Parameter CS_GAP, default 2, meaning: minimum CLK cycles CS stays high between frames; legal range 1..255.
REQ-003 Port CLK, input, 1, meaning: the only clock; all flops update on its rising edge.
REQ-004 Port RST_N, input, 1, meaning: asynchronous, active-low reset.
REQ-005 Port START, input, 1, meaning: request one 16-bit frame, sampled in IDLE only.
REQ-006 Port TX_DATA, input, 16, meaning: word to send, captured on the CLK edge that accepts START.
REQ-007 Port RX_DATA, output, 16, meaning: last received word, updated only when DONE is asserted.
REQ-008 Port BUSY, output, 1, meaning: high from START acceptance until return to IDLE.
REQ-009 Port DONE, output, 1, meaning: one-CLK pulse at frame completion.
REQ-010 Port SCLK, output, 1, meaning: serial clock to the slave, idle low.
REQ-011 Port CS, output, 1, meaning: active-low chip select, idle high.
REQ-012 Port MOSI, output, 1, meaning: serial data to the slave (slave SDI).
REQ-013 Port MISO, input, 1, meaning: serial data from the slave (slave SDO).

Function
REQ-014 The FSM SHALL have states IDLE, LEAD, XFER, TRAIL and GAP.
REQ-015 IDLE with START=1 SHALL go to LEAD on that edge with: tx_sr<=TX_DATA, CS<=0, BUSY<=1, MOSI<=TX_DATA[0], rx_sr<=0.
REQ-016 LEAD SHALL hold SCLK low for CLK_DIV cycles, then go to XFER.
REQ-017 XFER SHALL produce exactly 17 SCLK rising edges, numbered 0..16; each high phase and each low phase lasts CLK_DIV cycles.
REQ-018 Edge 0 SHALL be a synchronization edge: no MISO sampling and no MOSI change.
REQ-019 At rising edge k (k=1..16), the CLK edge that drives SCLK high SHALL sample the MISO value present before that edge: rx_sr<={MISO, rx_sr[15:1]}.
REQ-020 At the falling edge after rising edge k (k=1..15), MOSI SHALL change to tx bit k.
REQ-021 Bit order SHALL be LSB first in both directions; MOSI SHALL hold bit 15 after edge 16.
REQ-022 After the falling edge following edge 16, the block SHALL go to TRAIL, hold CS low with SCLK low for CLK_DIV cycles, then drive CS high.
REQ-023 On the edge that drives CS high, RX_DATA SHALL be loaded from rx_sr, DONE SHALL pulse for one cycle, and the FSM SHALL enter GAP.
REQ-024 CS low duration SHALL be exactly 35*CLK_DIV CLK cycles.
REQ-025 GAP SHALL keep CS high for CS_GAP cycles, then return to IDLE and drop BUSY.
REQ-026 START SHALL be ignored outside IDLE; it SHALL NOT be queued.
REQ-027 START held high continuously SHALL start a new frame on the first IDLE cycle after GAP.
REQ-028 SCLK SHALL be low whenever CS is high.
REQ-029 SCLK, CS and MOSI SHALL be driven directly from flops.
REQ-030 The half-period counter SHALL be 8 bits; the edge counter SHALL be 5 bits and SHALL saturate at 16.

Reset
REQ-031 RST_N=0 SHALL immediately force: FSM=IDLE, CS=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, RX_DATA=0, and all counters and shift registers to 0.
REQ-032 Reset mid-frame SHALL abort the frame without a DONE pulse; the first START after RST_N rises SHALL begin a clean frame.

Verification
REQ-033 Loopback (MOSI tied to MISO), CLK_DIV=1, TX_DATA=16'hA5C3 -> DONE pulses once, RX_DATA=16'hA5C3, CS low 35 cycles, 17 SCLK rises.
REQ-034 Slave model (samples and shifts on SCLK rise, LSB first, first edge after CS low is sync), slave DATA_IN=16'h1234, TX_DATA=16'hBEEF, CLK_DIV=4 -> slave DATA_OUT=16'hBEEF, RX_DATA=16'h1234, CS low 140 cycles.
REQ-035 START pulsed again 10 cycles after acceptance -> exactly one frame and one DONE; BUSY stays high throughout.
REQ-036 START held high, CS_GAP=2, two frames -> CS high exactly 2 cycles between frames, two DONE pulses.
REQ-037 RST_N low during edge 8 of a frame -> CS=1, SCLK=0, BUSY=0 the same cycle; no DONE; RX_DATA=0; the next frame is correct.
